vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
//   Sequences the VGA scan: decodes horizontal/vertical counter values into the
//   line-advance strobe for the vertical counter, sync pulses, display enable and pixel coords.
//   Sits between the H/V counters and the pixel datapath.
//   Start/stop FSM so software can arm or halt video on frame boundaries only.
// PARAMETERS
//   H_ACTIVE   640  visible pixels per line
//   H_FP       16   horizontal front porch (pixels)
//   H_SYNC     96   hsync width (pixels)
//   H_BP       48   horizontal back porch; H_TOTAL = sum of H_* = 800
//   V_ACTIVE   480  visible lines per frame
//   V_FP       10   vertical front porch (lines)
//   V_SYNC     2    vsync width (lines)
//   V_BP       32   vertical back porch; V_TOTAL = sum of V_* = 524 = vertical counter period
//   HSYNC_POL  0    active level of hsync (0 = active-low)
//   VSYNC_POL  0    active level of vsync (0 = active-low)
// PORTS
//   clk               in   1   system clock
//   rst               in   1   synchronous reset, active-high
//   en                in   1   pixel-tick enable; registered state advances only when 1
//   H_Count_Value     in   16  current horizontal count
//   V_Count_Value     in   16  current vertical count
//   start             in   1   arm video output (level-sampled when en=1)
//   stop              in   1   request halt at end of current frame
//   enable_V_counter  out  1   line-advance strobe to vertical counter (combinational)
//   hsync             out  1   horizontal sync, registered
//   vsync             out  1   vertical sync, registered
//   video_on          out  1   pixel visible, registered
//   pixel_x           out  10  visible column, registered
//   pixel_y           out  10  visible row, registered
//   frame_start       out  1   1-cycle pulse at first pixel of a displayed frame
//   stopped           out  1   1-cycle pulse when DRAIN completes
//   busy              out  1   state != IDLE
//   count_err         out  1   sticky: counter value out of range seen
// BEHAVIOUR
//   enable_V_counter = (H_Count_Value == H_TOTAL-1). Independent of state, en and rst.
//     The vertical counter applies its own en gating.
//   FSM, advances only on clk edge with en=1:
//     IDLE  -start & !stop-> ARMED
//     ARMED -stop-> IDLE
//     ARMED -(H==0 & V==0)-> RUN; frame_start=1 on this edge
//     RUN   -stop-> DRAIN
//     DRAIN -(H==H_TOTAL-1 & V==V_TOTAL-1)-> IDLE; stopped=1 on this edge
//     Simultaneous start & stop: stop wins. start in RUN/DRAIN is ignored.
//   Decode, state RUN/DRAIN, one-cycle latency from counts sampled at edge to outputs after it:
//     hsync active  iff H in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
//     vsync active  iff V in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
//     video_on      iff H<H_ACTIVE & V<V_ACTIVE
//     pixel_x = H[9:0], pixel_y = V[9:0] when video_on; both 0 otherwise
//   frame_start also pulses in RUN on every H==0 & V==0. Not in DRAIN.
//   IDLE/ARMED: syncs held inactive (~POL), video_on=0, pixel_x/y=0.
//   Out of range (H>=H_TOTAL or V>=V_TOTAL):
//     video_on=0, syncs inactive, count_err set. count_err stays set until rst.
//   en=0: all registered outputs hold their values. Pulses are forced to 0 after one clk cycle.
//   Reset values:
//     state=IDLE
//     hsync=~HSYNC_POL, vsync=~VSYNC_POL
//     video_on, pixel_x, pixel_y, frame_start, stopped, busy, count_err = 0
//   rst mid-frame: IDLE on the next edge. No stopped pulse.
// TESTING
//   rst, then start=1 at H=5,V=3 -> ARMED, outputs inactive until H=0,V=0; then frame_start=1 for 1 cycle, busy=1.
//   RUN, sweep H 0..799 at V=10 -> video_on for H 0..639; hsync low for H 656..751; enable_V_counter=1 only at H=799.
//   RUN, V 490..491 -> vsync low. V=480 -> video_on=0 for all H. V=523,H=799 -> next frame_start pulses.
//   stop at V=100 -> DRAIN, video continues; at H=799,V=523: stopped pulses, then IDLE, syncs inactive.
//   start&stop same cycle in IDLE -> stays IDLE. Inject H=900 -> count_err=1, held until rst.
//   en=0 for 20 cycles mid-line -> outputs frozen. rst during RUN -> all outputs at reset values after 1 edge.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: turns raw H/V counter values into sync pulses,
// display enable, pixel coordinates and a line-advance strobe, with a
// start/stop FSM that only arms or halts video on frame boundaries.
module vga_timing_ctrl #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 32,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] H_Count_Value,
  input  logic [15:0] V_Count_Value,
  input  logic        start,
  input  logic        stop,
  output logic        enable_V_counter,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic        stopped,
  output logic        busy,
  output logic        count_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST       = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST       = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_TOTAL_W    = 16'(H_TOTAL);
  localparam logic [15:0] V_TOTAL_W    = 16'(V_TOTAL);
  localparam logic [15:0] H_ACTIVE_W   = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACTIVE_W   = 16'(V_ACTIVE);
  localparam logic [15:0] H_SYNC_FIRST = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] H_SYNC_LAST  = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] V_SYNC_FIRST = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] V_SYNC_LAST  = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic w_frameOrigin;
  logic w_frameEnd;
  logic w_outOfRange;
  logic w_decodeActive;
  logic w_frameStart;
  logic w_drainDone;
  logic w_hsyncActive;
  logic w_vsyncActive;
  logic w_visible;

  // The vertical counter does its own en gating, so this strobe is a pure decode.
  assign enable_V_counter = (H_Count_Value == H_LAST);

  assign w_frameOrigin = (H_Count_Value == 16'd0) && (V_Count_Value == 16'd0);
  assign w_frameEnd    = (H_Count_Value == H_LAST) && (V_Count_Value == V_LAST);
  assign w_outOfRange  = (H_Count_Value >= H_TOTAL_W) || (V_Count_Value >= V_TOTAL_W);

  assign w_hsyncActive = (H_Count_Value >= H_SYNC_FIRST) && (H_Count_Value <= H_SYNC_LAST);
  assign w_vsyncActive = (V_Count_Value >= V_SYNC_FIRST) && (V_Count_Value <= V_SYNC_LAST);
  assign w_visible     = (H_Count_Value < H_ACTIVE_W) && (V_Count_Value < V_ACTIVE_W);

  // Decoding keys off the state being entered, so the very first pixel of a
  // frame (the ARMED->RUN edge) is already displayed alongside frame_start.
  assign w_decodeActive = (w_stateNext == RUN) || (w_stateNext == DRAIN);

  assign busy = (r_state != IDLE);

  // Next-state logic; stop always beats start, and start is ignored once running.
  always_comb begin
    w_stateNext  = r_state;
    w_frameStart = 1'b0;
    w_drainDone  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) w_stateNext = ARMED;
      end
      ARMED: begin
        if (stop) begin
          w_stateNext = IDLE;
        end else if (w_frameOrigin) begin
          w_stateNext  = RUN;
          w_frameStart = 1'b1;
        end
      end
      RUN: begin
        if (stop) w_stateNext = DRAIN;
        else if (w_frameOrigin) w_frameStart = 1'b1;
      end
      DRAIN: begin
        if (w_frameEnd) begin
          w_stateNext = IDLE;
          w_drainDone = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State register; only pixel ticks advance the sequence.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else if (en) r_state <= w_stateNext;
  end

  // Registered decode outputs; pulses clear on any non-tick cycle, everything else holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      video_on    <= 1'b0;
      pixel_x     <= 10'd0;
      pixel_y     <= 10'd0;
      frame_start <= 1'b0;
      stopped     <= 1'b0;
      count_err   <= 1'b0;
    end else begin
      frame_start <= en && w_frameStart;
      stopped     <= en && w_drainDone;
      if (en) begin
        count_err <= count_err || w_outOfRange;
        if (w_decodeActive && !w_outOfRange) begin
          hsync    <= w_hsyncActive ? HSYNC_POL : ~HSYNC_POL;
          vsync    <= w_vsyncActive ? VSYNC_POL : ~VSYNC_POL;
          video_on <= w_visible;
          pixel_x  <= w_visible ? H_Count_Value[9:0] : 10'd0;
          pixel_y  <= w_visible ? V_Count_Value[9:0] : 10'd0;
        end else begin
          hsync    <= ~HSYNC_POL;
          vsync    <= ~VSYNC_POL;
          video_on <= 1'b0;
          pixel_x  <= 10'd0;
          pixel_y  <= 10'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl: drives counter values directly, predicts
// every registered output with an independent model and compares one
// cycle later through a scoreboard queue.
module tb_vga_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [15:0] H_Count_Value = 16'd0;
  logic [15:0] V_Count_Value = 16'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        enable_V_counter;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        frame_start;
  logic        stopped;
  logic        busy;
  logic        count_err;

  int nChecks = 0;
  int nPass = 0;

  typedef struct {
    logic       hsync;
    logic       vsync;
    logic       videoOn;
    logic [9:0] pixelX;
    logic [9:0] pixelY;
    logic       frameStart;
    logic       stopped;
    logic       busy;
    logic       countErr;
  } expect_t;

  expect_t expQ[$];

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  int      mState = M_IDLE;
  expect_t mOut;

  vga_timing_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .H_Count_Value    (H_Count_Value),
    .V_Count_Value    (V_Count_Value),
    .start            (start),
    .stop             (stop),
    .enable_V_counter (enable_V_counter),
    .hsync            (hsync),
    .vsync            (vsync),
    .video_on         (video_on),
    .pixel_x          (pixel_x),
    .pixel_y          (pixel_y),
    .frame_start      (frame_start),
    .stopped          (stopped),
    .busy             (busy),
    .count_err        (count_err)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    nChecks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", tag, actual, expected, $time);
    else
      nPass++;
  endtask

  // Reference behaviour of one clock edge, written from the timing tables.
  task automatic modelStep(input int h, input int v, input int st, input int sp, input int e, input int r);
    int  nxt;
    logic oor;
    logic origin;
    logic last;
    if (r != 0) begin
      mState          = M_IDLE;
      mOut.hsync      = 1'b1;
      mOut.vsync      = 1'b1;
      mOut.videoOn    = 1'b0;
      mOut.pixelX     = 10'd0;
      mOut.pixelY     = 10'd0;
      mOut.frameStart = 1'b0;
      mOut.stopped    = 1'b0;
      mOut.countErr   = 1'b0;
    end else if (e == 0) begin
      mOut.frameStart = 1'b0;
      mOut.stopped    = 1'b0;
    end else begin
      oor    = (h >= 800) || (v >= 524);
      origin = (h == 0) && (v == 0);
      last   = (h == 799) && (v == 523);
      nxt    = mState;
      mOut.frameStart = 1'b0;
      mOut.stopped    = 1'b0;
      if (mState == M_IDLE && st != 0 && sp == 0) nxt = M_ARMED;
      if (mState == M_ARMED && sp != 0) nxt = M_IDLE;
      if (mState == M_ARMED && sp == 0 && origin) begin
        nxt = M_RUN;
        mOut.frameStart = 1'b1;
      end
      if (mState == M_RUN && sp != 0) nxt = M_DRAIN;
      if (mState == M_RUN && sp == 0 && origin) mOut.frameStart = 1'b1;
      if (mState == M_DRAIN && last) begin
        nxt = M_IDLE;
        mOut.stopped = 1'b1;
      end
      mState = nxt;
      if (oor) mOut.countErr = 1'b1;
      if ((nxt == M_RUN || nxt == M_DRAIN) && !oor) begin
        mOut.hsync   = !(h >= 656 && h <= 751);
        mOut.vsync   = !(v >= 490 && v <= 491);
        mOut.videoOn = (h < 640) && (v < 480);
        mOut.pixelX  = mOut.videoOn ? 10'(h) : 10'd0;
        mOut.pixelY  = mOut.videoOn ? 10'(v) : 10'd0;
      end else begin
        mOut.hsync   = 1'b1;
        mOut.vsync   = 1'b1;
        mOut.videoOn = 1'b0;
        mOut.pixelX  = 10'd0;
        mOut.pixelY  = 10'd0;
      end
    end
    mOut.busy = (mState != M_IDLE);
  endtask

  // Drive one cycle of inputs, predict the result, then compare after the edge.
  task automatic applyStimulus(input int h, input int v, input int st, input int sp, input int e, input int r);
    expect_t exp;
    @(negedge clk);
    H_Count_Value = 16'(h);
    V_Count_Value = 16'(v);
    start = (st != 0);
    stop  = (sp != 0);
    en    = (e != 0);
    rst   = (r != 0);
    #1;
    checkOutput("enable_V_counter", 16'(enable_V_counter), 16'(h == 799));
    modelStep(h, v, st, sp, e, r);
    expQ.push_back(mOut);
    @(posedge clk);
    #1;
    exp = expQ.pop_front();
    checkOutput("hsync",       16'(hsync),       16'(exp.hsync));
    checkOutput("vsync",       16'(vsync),       16'(exp.vsync));
    checkOutput("video_on",    16'(video_on),    16'(exp.videoOn));
    checkOutput("pixel_x",     16'(pixel_x),     16'(exp.pixelX));
    checkOutput("pixel_y",     16'(pixel_y),     16'(exp.pixelY));
    checkOutput("frame_start", 16'(frame_start), 16'(exp.frameStart));
    checkOutput("stopped",     16'(stopped),     16'(exp.stopped));
    checkOutput("busy",        16'(busy),        16'(exp.busy));
    checkOutput("count_err",   16'(count_err),   16'(exp.countErr));
  endtask

  // Directed scenario sequence covering arm, run, sync windows, freeze, drain and errors.
  initial begin
    $display("[TB] starting vga_timing_ctrl bench");

    applyStimulus(799, 0, 0, 0, 1, 1);
    applyStimulus(5, 3, 1, 0, 1, 0);
    for (int i = 6; i < 10; i++) applyStimulus(i, 3, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 0);

    for (int h = 0; h < 800; h++) applyStimulus(h, 10, 0, 0, 1, 0);

    for (int v = 489; v <= 492; v++) begin
      applyStimulus(0, v, 0, 0, 1, 0);
      applyStimulus(700, v, 0, 0, 1, 0);
    end
    for (int h = 0; h < 16; h++) applyStimulus(h, 480, 0, 0, 1, 0);
    applyStimulus(639, 480, 0, 0, 1, 0);
    applyStimulus(639, 479, 0, 0, 1, 0);

    applyStimulus(799, 523, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(320, 200, 0, 0, 1, 0);

    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++)
      applyStimulus(100 + i, 50, int'(i % 3 == 0), int'(i % 5 == 0), 0, 0);
    applyStimulus(101, 50, 0, 0, 1, 0);

    applyStimulus(50, 100, 0, 1, 1, 0);
    applyStimulus(51, 100, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(700, 10, 0, 0, 1, 0);
    applyStimulus(799, 523, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    applyStimulus(5, 5, 1, 1, 1, 0);
    applyStimulus(6, 5, 0, 0, 1, 0);
    applyStimulus(5, 5, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);

    applyStimulus(7, 5, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(900, 10, 0, 0, 1, 0);
    applyStimulus(10, 10, 0, 0, 1, 0);
    applyStimulus(5, 600, 0, 0, 1, 0);
    applyStimulus(700, 491, 0, 0, 1, 0);

    applyStimulus(20, 20, 0, 0, 1, 1);
    applyStimulus(21, 20, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
